// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the MIPS multiply/divide unit.
// The DIV state exists only when MDU_DIV_EN is defined.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mdu_state_e;
`endif

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider, one quotient bit per cycle, with magnitude/sign fix-up.
// done is asserted combinationally during the final iteration cycle, with quotient/remainder valid.
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, dvsr;
    logic             q_neg, r_neg, by_zero;
    logic             sa, sb, ge;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;

    assign sa = is_signed && a[WIDTH-1];
    assign sb = is_signed && b[WIDTH-1];

    // rem always stays below dvsr, so bit WIDTH of trial is a clean borrow flag
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr};
    assign ge      = !trial[WIDTH];
    assign rem_nxt = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ge};

    assign done      = run && (cnt == LAST);
    assign quotient  = by_zero ? '1 : (q_neg ? -quo_nxt : quo_nxt);
    assign remainder = r_neg ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            by_zero <= 1'b0;
        end else if (start) begin
            run     <= 1'b1;
            cnt     <= '0;
            quo     <= sa ? -a : a;
            rem     <= '0;
            dvsr    <= sb ? -b : b;
            q_neg   <= sa ^ sb;
            r_neg   <= sa;
            by_zero <= (b == '0);
        end else if (run) begin
            cnt <= cnt + 1'b1;
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit feeding architectural HI/LO.
// Divider compiled in only when MDU_DIV_EN is defined; otherwise DIV/DIVU pulse done and leave HI/LO alone.
module mdu_muldiv
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state, state_nxt;
    mdu_op_e            op_e;
    logic               accept, mul_start, mul_last, div_start;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt, prod;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic               neg, sa, sb;

    assign op_e      = mdu_op_e'(op);
    assign accept    = start && !busy;
    assign mul_start = accept && (op_e == MDU_MULT || op_e == MDU_MULTU);
    assign div_start = accept && (op_e == MDU_DIV || op_e == MDU_DIVU);
    assign mul_last  = (state == ST_MUL) && (cnt == LAST);

`ifdef MDU_DIV_EN
    logic             div_done;
    logic [WIDTH-1:0] div_q, div_r;

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (op_e == MDU_DIV),
        .a         (a),
        .b         (b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mul_start) state_nxt = ST_MUL;
`ifdef MDU_DIV_EN
                else if (div_start) state_nxt = ST_DIV;
`endif
            end
            ST_MUL:  if (cnt == LAST) state_nxt = ST_IDLE;
`ifdef MDU_DIV_EN
            ST_DIV:  if (div_done) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Shift-add on magnitudes; the final step's sum is sign-fixed and written straight to HI/LO
    assign sa      = (op_e == MDU_MULT) && a[WIDTH-1];
    assign sb      = (op_e == MDU_MULT) && b[WIDTH-1];
    assign mag_a   = sa ? -a : a;
    assign mag_b   = sb ? -b : b;
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign prod    = neg ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (mul_start) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            neg    <= sa ^ sb;
        end else if (state == ST_MUL) begin
            cnt    <= cnt + 1'b1;
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
`ifdef MDU_DIV_EN
            done <= mul_last || div_done;
`else
            done <= mul_last || div_start;
`endif
            if (mul_last) begin
                {hi, lo} <= prod;
`ifdef MDU_DIV_EN
            end else if (div_done) begin
                hi <= div_r;
                lo <= div_q;
`endif
            end else if (accept && op_e == MDU_MTHI) begin
                hi <= a;
            end else if (accept && op_e == MDU_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_muldiv.sv
// Self-checking bench for mdu_muldiv: directed boundary cases plus randomized ops
// against an arithmetic reference model (divider expectations follow MDU_DIV_EN).
module tb_mdu_muldiv;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] oh, input logic [31:0] ol);
        longint sx, sy, p;
        logic [63:0] u;
        logic [31:0] q, r;
        case (o)
            3'd0: begin sx = $signed(x); sy = $signed(y); p = sx * sy; return p; end
            3'd1: begin u = {32'd0, x} * {32'd0, y}; return u; end
            3'd2: begin
                if (!DIV_EN) return {oh, ol};
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            3'd3: begin
                if (!DIV_EN) return {oh, ol};
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd4:    return {x, ol};
            3'd5:    return {oh, x};
            default: return {oh, ol};
        endcase
    endfunction

    function automatic bit is_iter(input logic [2:0] o);
        return (o <= 3'd1) || (DIV_EN && (o == 3'd2 || o == 3'd3));
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Caller is at a negedge; returns at the negedge following the accepting edge
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic check_iter(input string name, input logic [63:0] expv, input bit inject);
        int busy_n = 0;
        int done_n = 0;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 32 && busy) busy_n++;
            if (done) done_n++;
            if (inject && k == 5) begin
                start = 1'b1; op = 3'($urandom_range(0, 5)); a = $urandom | 32'h1; b = $urandom | 32'h1;
            end
            if (inject && k == 6) start = 1'b0;
            if (k == 16) begin
                checks++;
                if ({hi, lo} !== {m_hi, m_lo}) begin
                    errors++;
                    $display("FAIL %s hold: hi=%h lo=%h during busy, want %h %h", name, hi, lo, m_hi, m_lo);
                end
            end
        end
        checks++;
        if (busy_n != 32 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: high %0d cycles, busy_now=%b, want 32 cycles then 0", name, busy_n, busy);
        end
        checks++;
        if (done !== 1'b1 || done_n != 1) begin
            errors++;
            $display("FAIL %s done: done_now=%b pulses=%0d, want 1 and 1", name, done, done_n);
        end
        checks++;
        if ({hi, lo} !== expv) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, expv[63:32], expv[31:0]);
        end
        {m_hi, m_lo} = expv;
    endtask

    task automatic check_quick(input string name, input logic [63:0] expv, input logic exp_done);
        checks++;
        if (busy !== 1'b0 || done !== exp_done || {hi, lo} !== expv) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b hi=%h lo=%h, want busy=0 done=%b hi=%h lo=%h",
                     name, busy, done, hi, lo, exp_done, expv[63:32], expv[31:0]);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b, want 0 0", name, done, busy);
        end
        {m_hi, m_lo} = expv;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
        logic [63:0] expv;
        expv = model(o, x, y, m_hi, m_lo);
        @(negedge clk);
        launch(o, x, y);
        if (is_iter(o)) check_iter(name, expv, inject);
        else            check_quick(name, expv, (o == 3'd2 || o == 3'd3));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mul();
        run_op("mult_neg1x5", 3'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_minxmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mult_mixed", 3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b0);
    endtask

    task automatic test_div();
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_by0", 3'd3, 32'd100, 32'd0, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op("divu_big", 3'd3, 32'hFFFF_FFF0, 32'd7, 1'b0);
    endtask

    task automatic test_move();
        run_op("mthi", 3'd4, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
        run_op("mtlo", 3'd5, 32'hCAFE_0001, 32'd0, 1'b0);
        run_op("reserved6", 3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);
        run_op("reserved7", 3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0);
    endtask

    task automatic test_ignore_while_busy();
        run_op("mult_ignore2nd", 3'd0, 32'h0000_0123, 32'hFFFF_FF00, 1'b1);
        run_op("multu_ignore2nd", 3'd1, $urandom, $urandom, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] e1, e2;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        e1 = model(3'd1, x1, y1, m_hi, m_lo);
        @(negedge clk);
        launch(3'd1, x1, y1);
        check_iter("b2b_first", e1, 1'b0);
        e2 = model(3'd0, x2, y2, m_hi, m_lo);
        launch(3'd0, x2, y2);
        check_iter("b2b_second", e2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int done_n = 0;
        @(negedge clk);
        launch(3'd0, 32'h1234_5678, 32'h0000_0FFF);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/busy after reset, want 0", done_n);
        end
        run_op("mult_3x4", 3'd0, 32'd3, 32'd4, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] o;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            run_op("random", o, rnd_operand(), rnd_operand(), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_move();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_muldiv.md
# mdu_muldiv

Iterative multiply/divide unit for the single-cycle MIPS core. It consumes the two register-file read operands (rs on RD1, rt on RD2) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results go into architectural HI/LO registers, which feed the MFHI/MFLO write-back path into the register file. The controller stalls the PC while `busy` is high.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `start`  in  1  request; sampled at each rising edge.
- `op`  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 reserved.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  iterative operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- `hi`  out  WIDTH  architectural HI.
- `lo`  out  WIDTH  architectural LO.

## Operation
- States: IDLE, MUL, DIV.
- Accept condition: `start && !busy` at a rising edge.
  - `start` while busy: ignored, no queuing.
  - Reserved `op`: ignored.
- MTHI/MTLO (IDLE only): `hi` (or `lo`) takes `a` on the accepting edge. No busy, no done.
- MULT/MULTU:
  - Operands are latched into working registers; the unit enters MUL.
  - Shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
  - Signed variant: operate on magnitudes, then negate the 64-bit product if the operand signs differ.
  - Result: `hi` = product[63:32], `lo` = product[31:0].
- DIV/DIVU:
  - Operands are latched; the unit enters DIV.
  - Restoring division, one quotient bit per cycle.
  - `lo` = quotient, truncated toward zero. `hi` = remainder; in the signed case its sign follows the dividend.
- Boundary rules:
  - Divide by zero: `lo`=0xFFFFFFFF, `hi`=`a`. Same timing as any other divide.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - MULT of 0x80000000 × 0x80000000: `hi`=0x40000000, `lo`=0.
- `hi`/`lo` hold their previous values for the whole operation. Working registers are internal, so MFHI/MFLO during busy returns the old values.
- Reset mid-operation: aborts the operation with no `done` and returns to IDLE.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, working registers 0.
- Edge 0 accepts the request. `busy`=1 after edge 0, for exactly WIDTH (32) cycles.
- On edge 32 after acceptance:
  - `hi`/`lo` are updated.
  - `busy` falls.
  - `done`=1 for that one cycle.
- A new `start` is accepted on the same edge that `done` is high, since `busy` is already 0 during that cycle. Back-to-back ops therefore lose no cycle.
- MTHI/MTLO latency: 1 edge.
- `done` is registered; `busy` is decoded from state (non-IDLE).

## Configuration
- `MDU_DIV_EN` defined:
  - Divider compiled in; DIV/DIVU behave as specified above.
- `MDU_DIV_EN` undefined:
  - Divider logic and the DIV state are removed.
  - DIV/DIVU are accepted in IDLE. `busy` stays 0. `done` pulses on the accepting edge's following cycle. `hi`/`lo` are unchanged.

## Structure
- Shared package `mdu_pkg`:
  - `op` encodings (MDU_MULT … MDU_MTLO).
  - State enum.
  - Iteration count constant (WIDTH).
- Sub-module `mdu_div_core`:
  - Restoring divider: start, done, quotient, remainder, magnitude/sign fix-up.
  - Instantiated only under `MDU_DIV_EN`.
- Multiplier datapath and control stay in the top module.

## Test plan
- MULT a=0xFFFFFFFF, b=5:
  - `busy` high 32 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFB; exactly one `done`.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2:
  - `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- Divide edge cases:
  - DIVU a=100, b=0: `lo`=0xFFFFFFFF, `hi`=0x00000064.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- MTHI a=0x1234 in IDLE:
  - `hi`=0x1234 after one edge; `lo` unchanged; no `done`.
  - A second `start` during a MULT is ignored (result matches the first op only).
- MULT, then `rst` pulsed at cycle 10:
  - `busy`=0, `hi`=`lo`=0 immediately; no `done`.
  - The next MULT 3×4 gives `lo`=12, `hi`=0.
